synch_fifo_prog: RTL and testbench

//  Single-clock parametrised FIFO for NI initiator/target buffering; successor of the basic synchronous FIFO.

---
 rtl/synch_fifo_prog_pkg.sv | 15 +
 rtl/synch_fifo_prog_mem_elem.sv | 29 ++
 rtl/synch_fifo_prog.sv | 130 +++++++++++++
 tb/tb_synch_fifo_prog.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/synch_fifo_prog_pkg.sv
// Shared defaults and parameter sanity helper for the programmable synchronous FIFO.
package synch_fifo_prog_pkg;

    localparam int DEF_DSIZE     = 8;
    localparam int DEF_ASIZE     = 4;
    localparam int DEF_FWFT      = 0;
    localparam int DEF_AF_THRESH = 12;
    localparam int DEF_AE_THRESH = 2;

    // Thresholds are legal when 0 <= ae < af <= depth.
    function automatic bit thresh_valid(input int ae, input int af, input int asize);
        return (ae >= 0) && (ae < af) && (af <= (1 << asize));
    endfunction

endpackage

// File: rtl/synch_fifo_prog_mem_elem.sv
// One storage word of the FIFO: loads d on a clock edge while the active-low write enable is low.
module synch_fifo_prog_mem_elem #(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             we_n,
    input  logic [DSIZE-1:0] d,
    output logic [DSIZE-1:0] q
);

    logic [DSIZE-1:0] q_d;
    logic [DSIZE-1:0] q_q;

    // Next word: new data when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (!we_n) q_d = d;
    end

    // Storage register.
    // NOTE: storage words carry no reset; the pointers alone decide which words are valid,
    // and leaving the array unreset keeps it mappable onto plain flops or RAM.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/synch_fifo_prog.sv
// Single-clock FIFO with optional first-word-fall-through, almost flags, flush and sticky errors.
module synch_fifo_prog
    import synch_fifo_prog_pkg::*;
#(
    parameter int DSIZE     = DEF_DSIZE,
    parameter int ASIZE     = DEF_ASIZE,
    parameter int FWFT      = DEF_FWFT,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   num_stored_words,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH  = 1 << ASIZE;
    localparam logic [ASIZE:0] AF_LVL = (ASIZE + 1)'(AF_THRESH);
    localparam logic [ASIZE:0] AE_LVL = (ASIZE + 1)'(AE_THRESH);
    localparam logic [ASIZE:0] PTR_ONE = (ASIZE + 1)'(1);

    if (!thresh_valid(AE_THRESH, AF_THRESH, ASIZE)) begin : g_bad_thresh
        $error("synch_fifo_prog: need AE_THRESH < AF_THRESH <= 2**ASIZE");
    end

    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push_ok;
    logic             pop_ok;
    logic [DEPTH-1:0] wr_en_n;
    logic [DSIZE-1:0] cell_q [DEPTH];
    logic [DSIZE-1:0] head_data;

    // Status is a pure function of the registered pointers, so it only moves after an edge.
    assign rempty           = (wptr_q == rptr_q);
    assign wfull            = (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]) && (wptr_q[ASIZE] != rptr_q[ASIZE]);
    assign num_stored_words = wptr_q - rptr_q;
    assign almost_full      = (num_stored_words >= AF_LVL);
    assign almost_empty     = (num_stored_words <= AE_LVL);
    assign overflow         = overflow_q;
    assign underflow        = underflow_q;

    // Flags are judged on pre-edge state, so a full FIFO still pops and an empty one still pushes.
    assign push_ok = winc && !wfull && !flush;
    assign pop_ok  = rinc && !rempty && !flush;

    // Storage array with one-hot active-low write enables decoded from the write pointer.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign wr_en_n[i] = !(push_ok && (wptr_q[ASIZE-1:0] == ASIZE'(i)));
        synch_fifo_prog_mem_elem #(.DSIZE(DSIZE)) u_cell (
            .clk  (clk),
            .we_n (wr_en_n[i]),
            .d    (wdata),
            .q    (cell_q[i])
        );
    end

    assign head_data = cell_q[rptr_q[ASIZE-1:0]];

    // Next-state for pointers and sticky error flags; flush overrides all requests.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PTR_ONE;
            if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
            if (winc && wfull)  overflow_d  = 1'b1;
            if (rinc && rempty) underflow_d = 1'b1;
        end
    end

    // Pointer and flag registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to zero while empty so stale storage never leaks out.
        assign rdata = rempty ? '0 : head_data;
    end else begin : g_reg_read
        logic [DSIZE-1:0] rdata_q, rdata_d;

        // Registered read: capture the head word on an accepted pop, clear on flush.
        always_comb begin
            rdata_d = rdata_q;
            if (flush)       rdata_d = '0;
            else if (pop_ok) rdata_d = head_data;
        end

        // Read data register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rdata_q <= '0;
            else     rdata_q <= rdata_d;
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_synch_fifo_prog.sv
// Directed bench: two FIFOs (registered read and FWFT) driven by the same stimulus.
module tb_synch_fifo_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       winc;
    logic       rinc;
    logic [7:0] wdata;

    logic [7:0] d0_rdata, d1_rdata;
    logic       d0_wfull, d1_wfull, d0_rempty, d1_rempty;
    logic       d0_af, d1_af, d0_ae, d1_ae;
    logic [2:0] d0_cnt, d1_cnt;
    logic       d0_ovf, d1_ovf, d0_unf, d1_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    synch_fifo_prog #(.DSIZE(8), .ASIZE(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(d0_rdata), .wfull(d0_wfull), .rempty(d0_rempty), .almost_full(d0_af),
        .almost_empty(d0_ae), .num_stored_words(d0_cnt), .overflow(d0_ovf), .underflow(d0_unf)
    );

    synch_fifo_prog #(.DSIZE(8), .ASIZE(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(d1_rdata), .wfull(d1_wfull), .rempty(d1_rempty), .almost_full(d1_af),
        .almost_empty(d1_ae), .num_stored_words(d1_cnt), .overflow(d1_ovf), .underflow(d1_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] wd, input logic r, input logic f);
        winc  = w;
        wdata = wd;
        rinc  = r;
        flush = f;
        @(posedge clk);
        #1;
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic status(input string tag, input int cnt, input logic full, input logic empty,
                          input logic af, input logic ae, input logic ovf, input logic unf);
        check({tag, " d0 count"}, 32'(d0_cnt), cnt);
        check({tag, " d1 count"}, 32'(d1_cnt), cnt);
        check({tag, " d0 wfull"}, 32'(d0_wfull), 32'(full));
        check({tag, " d1 wfull"}, 32'(d1_wfull), 32'(full));
        check({tag, " d0 rempty"}, 32'(d0_rempty), 32'(empty));
        check({tag, " d1 rempty"}, 32'(d1_rempty), 32'(empty));
        check({tag, " d0 almost_full"}, 32'(d0_af), 32'(af));
        check({tag, " d1 almost_full"}, 32'(d1_af), 32'(af));
        check({tag, " d0 almost_empty"}, 32'(d0_ae), 32'(ae));
        check({tag, " d1 almost_empty"}, 32'(d1_ae), 32'(ae));
        check({tag, " d0 overflow"}, 32'(d0_ovf), 32'(ovf));
        check({tag, " d1 overflow"}, 32'(d1_ovf), 32'(ovf));
        check({tag, " d0 underflow"}, 32'(d0_unf), 32'(unf));
        check({tag, " d1 underflow"}, 32'(d1_unf), 32'(unf));
    endtask

    task automatic rd(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        check({tag, " d0 rdata"}, 32'(d0_rdata), 32'(e0));
        check({tag, " d1 rdata"}, 32'(d1_rdata), 32'(e1));
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        status("reset", 0, 0, 1, 0, 1, 0, 0);
        rd("reset", 8'h00, 8'h00);
        rst = 1'b0;

        // Fill A0..A3: almost_empty drops at 2, almost_full at 3, wfull at 4.
        cyc(1, 8'hA0, 0, 0);
        status("fill1", 1, 0, 0, 0, 1, 0, 0);
        rd("fill1", 8'h00, 8'hA0);
        cyc(1, 8'hA1, 0, 0);
        status("fill2", 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        status("fill3", 3, 0, 0, 1, 0, 0, 0);
        cyc(1, 8'hA3, 0, 0);
        status("fill4", 4, 1, 0, 1, 0, 0, 0);

        // Push while full: rejected, overflow sticks.
        cyc(1, 8'hA4, 0, 0);
        status("ovf", 4, 1, 0, 1, 0, 1, 0);

        // Full with push+pop: only the pop is taken.
        cyc(1, 8'hB0, 1, 0);
        status("full_rw", 3, 0, 0, 1, 0, 1, 0);
        rd("full_rw", 8'hA0, 8'hA1);
        cyc(0, 8'h00, 1, 0);
        status("pop2", 2, 0, 0, 0, 0, 1, 0);
        rd("pop2", 8'hA1, 8'hA2);
        cyc(0, 8'h00, 1, 0);
        status("pop3", 1, 0, 0, 0, 1, 1, 0);
        rd("pop3", 8'hA2, 8'hA3);
        cyc(0, 8'h00, 1, 0);
        status("pop4", 0, 0, 1, 0, 1, 1, 0);
        rd("pop4", 8'hA3, 8'h00);

        // Empty with push+pop: only the push is taken, no bypass.
        cyc(1, 8'hC5, 1, 0);
        status("empty_rw", 1, 0, 0, 0, 1, 1, 1);
        rd("empty_rw", 8'hA3, 8'hC5);

        // Ten push/pop pairs at occupancy 1 walk the pointers across the wrap.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(8'h10 + i), 1, 0);
            check("wrap d0 count", 32'(d0_cnt), 1);
            check("wrap d0 wfull", 32'(d0_wfull), 0);
            check("wrap d1 wfull", 32'(d1_wfull), 0);
            rd("wrap", (i == 0) ? 8'hC5 : 8'(8'h10 + i - 1), 8'(8'h10 + i));
        end
        cyc(0, 8'h00, 1, 0);
        status("wrap_end", 0, 0, 1, 0, 1, 1, 1);
        rd("wrap_end", 8'h19, 8'h00);

        // Flush with requests: everything cleared, pushed word dropped, flags not set.
        cyc(1, 8'hD0, 0, 0);
        cyc(1, 8'hD1, 0, 0);
        cyc(1, 8'hD2, 0, 0);
        status("preflush", 3, 0, 0, 1, 0, 1, 1);
        rd("preflush", 8'h19, 8'hD0);
        cyc(1, 8'hEE, 1, 1);
        status("flush", 0, 0, 1, 0, 1, 0, 0);
        rd("flush", 8'h00, 8'h00);
        cyc(0, 8'h00, 0, 0);
        status("postflush", 0, 0, 1, 0, 1, 0, 0);
        cyc(1, 8'h55, 0, 0);
        status("after_flush_push", 1, 0, 0, 0, 1, 0, 0);
        rd("after_flush_push", 8'h00, 8'h55);

        // Fill and overflow, then reset asynchronously mid-traffic.
        cyc(1, 8'h66, 0, 0);
        cyc(1, 8'h77, 0, 0);
        cyc(1, 8'h88, 0, 0);
        cyc(1, 8'h99, 0, 0);
        status("prereset", 4, 1, 0, 1, 0, 1, 0);
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'hAA;
        @(negedge clk);
        rst = 1'b1;
        #1;
        status("async_rst", 0, 0, 1, 0, 1, 0, 0);
        rd("async_rst", 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        winc = 1'b0;
        rinc = 1'b0;
        cyc(0, 8'h00, 0, 0);
        status("post_rst", 0, 0, 1, 0, 1, 0, 0);
        rd("post_rst", 8'h00, 8'h00);
        cyc(1, 8'h3C, 0, 0);
        status("post_rst_push", 1, 0, 0, 0, 1, 0, 0);
        rd("post_rst_push", 8'h00, 8'h3C);
        cyc(0, 8'h00, 1, 0);
        rd("post_rst_pop", 8'h3C, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
